// File: rtl/cnn_bn_relu_new_if.sv
// Pixel/parameter stream bundle between the conv adder, the BN+ReLU stage and its consumer.
interface cnn_bn_relu_new_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] pxl_in;
  logic                  valid_param_in;
  logic [DATA_WIDTH-1:0] param_in;
  logic [DATA_WIDTH-1:0] pxl_out;
  logic                  valid_out;
  logic                  param_ready;
  logic                  frame_done;
  logic                  err_drop;

  modport master (
    output valid_in, pxl_in, valid_param_in, param_in,
    input  pxl_out, valid_out, param_ready, frame_done, err_drop
  );

  modport slave (
    input  valid_in, pxl_in, valid_param_in, param_in,
    output pxl_out, valid_out, param_ready, frame_done, err_drop
  );
endinterface

// File: rtl/cnn_bn_relu_new.sv
// Folded batch-norm (y = x*scale + bias) followed by saturating ReLU, per output channel.
// Parameters are loaded serially once after reset; pixels then stream through a 3-stage pipe.
module cnn_bn_relu_new #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned FRAC_BITS       = 8,
  parameter int unsigned CHANNEL_NUM_OUT = 128,
  parameter int unsigned OUT_SIZE        = 16384
) (
  input  logic               clk,
  input  logic               reset,
  cnn_bn_relu_new_if.slave   bus
);

  localparam int unsigned CH_CNT_WIDTH = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int unsigned PX_CNT_WIDTH = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int unsigned LD_CNT_WIDTH = CH_CNT_WIDTH + 1;
  localparam int unsigned SUM_WIDTH    = DATA_WIDTH + 2;
  localparam int unsigned PROD_WIDTH   = 2 * DATA_WIDTH;

  localparam logic [LD_CNT_WIDTH-1:0] LD_LAST = LD_CNT_WIDTH'(2 * CHANNEL_NUM_OUT - 1);
  localparam logic [CH_CNT_WIDTH-1:0] CH_LAST = CH_CNT_WIDTH'(CHANNEL_NUM_OUT - 1);
  localparam logic [PX_CNT_WIDTH-1:0] PX_LAST = PX_CNT_WIDTH'(OUT_SIZE - 1);

  localparam logic signed [SUM_WIDTH-1:0] SAT_SUM = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]       SAT_OUT = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic {ST_LOAD, ST_RUN} state_t;

  state_t                   state_q;
  logic [LD_CNT_WIDTH-1:0]  ld_cnt_q;
  logic [CH_CNT_WIDTH-1:0]  ch_q;
  logic [PX_CNT_WIDTH-1:0]  px_q;
  logic                     param_ready_q;
  logic                     err_drop_q;

  logic signed [DATA_WIDTH-1:0] scale_mem [CHANNEL_NUM_OUT];
  logic signed [DATA_WIDTH-1:0] bias_mem  [CHANNEL_NUM_OUT];

  logic                         s1_vld_q;
  logic                         s1_last_q;
  logic signed [DATA_WIDTH-1:0] s1_pxl_q;
  logic signed [DATA_WIDTH-1:0] s1_scale_q;
  logic signed [DATA_WIDTH-1:0] s1_bias_q;
  logic                         s2_vld_q;
  logic                         s2_last_q;
  logic signed [SUM_WIDTH-1:0]  s2_sum_q;
  logic signed [SUM_WIDTH-1:0]  s2_sum_d;
  logic signed [PROD_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]        pxl_out_d;
  logic [DATA_WIDTH-1:0]        pxl_out_q;
  logic                         valid_out_q;
  logic                         frame_done_q;

  logic                         pix_accept;
  logic                         pix_last;
  logic                         param_wr;
  logic [CH_CNT_WIDTH-1:0]      ld_ch;

  assign pix_accept = bus.valid_in && (state_q == ST_RUN);
  assign pix_last   = (ch_q == CH_LAST) && (px_q == PX_LAST);
  assign param_wr   = !reset && bus.valid_param_in && (state_q == ST_LOAD);
  assign ld_ch      = ld_cnt_q[LD_CNT_WIDTH-1:1];

  // Control FSM: serial parameter load, then per-pixel channel/pixel counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_LOAD;
      ld_cnt_q      <= '0;
      ch_q          <= '0;
      px_q          <= '0;
      param_ready_q <= 1'b0;
      err_drop_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.valid_in) begin
            err_drop_q <= 1'b1;
          end
          if (bus.valid_param_in) begin
            if (ld_cnt_q == LD_LAST) begin
              ld_cnt_q      <= '0;
              state_q       <= ST_RUN;
              param_ready_q <= 1'b1;
            end else begin
              ld_cnt_q <= ld_cnt_q + LD_CNT_WIDTH'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.valid_in) begin
            if (px_q == PX_LAST) begin
              px_q <= '0;
              ch_q <= (ch_q == CH_LAST) ? '0 : ch_q + CH_CNT_WIDTH'(1);
            end else begin
              px_q <= px_q + PX_CNT_WIDTH'(1);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Parameter RAM: even load words are scales, odd words are biases; contents survive reset.
  always_ff @(posedge clk) begin
    if (param_wr) begin
      if (ld_cnt_q[0]) begin
        bias_mem[ld_ch] <= bus.param_in;
      end else begin
        scale_mem[ld_ch] <= bus.param_in;
      end
    end
  end

  // Stage-2 arithmetic: Q-format multiply, floor shift, bias add; operands stay within SUM_WIDTH.
  always_comb begin
    prod     = PROD_WIDTH'(s1_pxl_q) * PROD_WIDTH'(s1_scale_q);
    s2_sum_d = SUM_WIDTH'(prod >>> FRAC_BITS) + SUM_WIDTH'(s1_bias_q);
  end

  // Stage-3 ReLU with positive saturation.
  always_comb begin
    pxl_out_d = s2_sum_q[DATA_WIDTH-1:0];
    if (s2_sum_q[SUM_WIDTH-1]) begin
      pxl_out_d = '0;
    end else if (s2_sum_q > SAT_SUM) begin
      pxl_out_d = SAT_OUT;
    end
  end

  // Three-stage datapath; channel parameters are captured alongside the pixel in stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_pxl_q     <= '0;
      s1_scale_q   <= '0;
      s1_bias_q    <= '0;
      s2_vld_q     <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_sum_q     <= '0;
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      s1_vld_q <= pix_accept;
      if (pix_accept) begin
        s1_last_q  <= pix_last;
        s1_pxl_q   <= bus.pxl_in;
        s1_scale_q <= scale_mem[ch_q];
        s1_bias_q  <= bias_mem[ch_q];
      end
      s2_vld_q  <= s1_vld_q;
      s2_last_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        s2_sum_q <= s2_sum_d;
      end
      valid_out_q  <= s2_vld_q;
      frame_done_q <= s2_vld_q && s2_last_q;
      if (s2_vld_q) begin
        pxl_out_q <= pxl_out_d;
      end
    end
  end

  assign bus.pxl_out     = pxl_out_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.param_ready = param_ready_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_drop    = err_drop_q;

endmodule

// File: tb/tb_cnn_bn_relu_new.sv
// Scoreboard bench for cnn_bn_relu_new with 2 channels of 4 pixels each.
module tb_cnn_bn_relu_new;

  localparam int unsigned DW = 16;
  localparam int unsigned CH = 2;
  localparam int unsigned OS = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cnn_bn_relu_new_if #(.DATA_WIDTH(DW)) bus ();

  cnn_bn_relu_new #(
    .DATA_WIDTH(DW),
    .FRAC_BITS(8),
    .CHANNEL_NUM_OUT(CH),
    .OUT_SIZE(OS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [31:0] stamp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          fd_cnt = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: floor-shifted product plus bias, ReLU, saturate to max positive.
  function automatic logic [15:0] model(input logic [15:0] p, input logic [15:0] s,
                                        input logic [15:0] b);
    longint prod;
    longint sum;
    prod = longint'($signed(p)) * longint'($signed(s));
    sum  = (prod >>> 8) + longint'($signed(b));
    if (sum < 0) return 16'h0000;
    if (sum > 32767) return 16'h7FFF;
    return 16'(sum);
  endfunction

  // Monitor: pops one expectation per output strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.valid_out) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output", bus.pxl_out);
        end else begin
          e = sb_q.pop_front();
          chk("pxl_out", 32'(bus.pxl_out), 32'(e.data));
          chk("frame_done", 32'(bus.frame_done), 32'(e.last));
          chk("latency", cyc - e.stamp, 32'd3);
        end
        if (bus.frame_done) fd_cnt++;
      end else if (bus.frame_done) begin
        n_vec++;
        n_err++;
        $display("FAIL stray_frame_done: got 1, expected 0 without valid_out");
      end
    end
  end

  task automatic px(input logic [15:0] d, input logic [15:0] exp_v, input logic last);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.pxl_in   = d;
    sb_q.push_back('{data: exp_v, last: last, stamp: cyc});
  endtask

  task automatic px_drop(input logic [15:0] d);
    @(negedge clk);
    bus.valid_in = 1'b1;
    bus.pxl_in   = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_in       = 1'b0;
      bus.valid_param_in = 1'b0;
    end
  endtask

  task automatic load(input logic [15:0] s0, input logic [15:0] b0,
                      input logic [15:0] s1, input logic [15:0] b1);
    logic [15:0] w[4];
    w = '{s0, b0, s1, b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.valid_in = 1'b0;
      if (i == 3) chk("param_ready_pre", 32'(bus.param_ready), 32'd0);
      bus.valid_param_in = 1'b1;
      bus.param_in       = w[i];
    end
    @(negedge clk);
    bus.valid_param_in = 1'b0;
    chk("param_ready", 32'(bus.param_ready), 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    bus.valid_in = 1'b0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs missing, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b1;
    bus.valid_in       = 1'b0;
    bus.valid_param_in = 1'b0;
    @(negedge clk);
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_param_ready", 32'(bus.param_ready), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_err_drop", 32'(bus.err_drop), 32'd0);
    chk("rst_pxl_out", 32'(bus.pxl_out), 32'd0);
    @(negedge clk);
    sb_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fd0;
    logic [15:0] sc[2];
    logic [15:0] bi[2];
    logic [15:0] d;

    reset              = 1'b1;
    bus.valid_in       = 1'b0;
    bus.pxl_in         = '0;
    bus.valid_param_in = 1'b0;
    bus.param_in       = '0;
    do_reset();

    // Pixel before parameters are loaded is dropped and flagged.
    px_drop(16'h0200);
    idle(5);
    chk("err_drop_set", 32'(bus.err_drop), 32'd1);

    // Set A: ch0 = 1.0*x + 0.5, ch1 = 2.0*x.
    load(16'h0100, 16'h0080, 16'h0200, 16'h0000);
    chk("err_drop_sticky", 32'(bus.err_drop), 32'd1);
    fd0 = fd_cnt;
    for (int i = 0; i < 4; i++) px(16'h0200, 16'h0280, 1'b0);
    for (int i = 0; i < 4; i++) px(16'h0200, 16'h0400, i == 3);
    drain();
    chk("frames_a", 32'(fd_cnt - fd0), 32'd1);

    // Negative result is clamped to zero.
    px(16'hFE00, 16'h0000, 1'b0);
    drain();

    // Reset mid-frame after three pixels: only the first one has left the pipe.
    for (int i = 0; i < 3; i++) px(16'h0200, 16'h0280, 1'b0);
    do_reset();
    px_drop(16'h0200);
    idle(5);
    chk("err_drop_reload", 32'(bus.err_drop), 32'd1);
    chk("param_ready_reload", 32'(bus.param_ready), 32'd0);
    do_reset();

    // Set B: ch0 = 2.0*x + 1.0 (saturation edges), ch1 = 0.5*x + 0.25 (floor shift).
    load(16'h0200, 16'h0100, 16'h0080, 16'h0040);
    fd0 = fd_cnt;
    px(16'h7000, 16'h7FFF, 1'b0);
    px(16'h3FFF, 16'h7FFF, 1'b0);
    px(16'h3F7F, 16'h7FFE, 1'b0);
    px(16'hFF80, 16'h0000, 1'b0);
    px(16'hFFFF, 16'h003F, 1'b0);
    px(16'h0001, 16'h0040, 1'b0);
    px(16'hFF00, 16'h0000, 1'b0);
    px(16'h0100, 16'h00C0, 1'b1);
    drain();
    chk("frames_b", 32'(fd_cnt - fd0), 32'd1);

    // Two consecutive frames with random gaps, parameters reused.
    sc[0] = 16'h0200; bi[0] = 16'h0100;
    sc[1] = 16'h0080; bi[1] = 16'h0040;
    fd0 = fd_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        idle($urandom_range(0, 2));
        d = 16'($urandom);
        px(d, model(d, sc[i / 4], bi[i / 4]), i == 7);
      end
    end
    drain();
    chk("frames_rand", 32'(fd_cnt - fd0), 32'd2);
    chk("param_ready_hold", 32'(bus.param_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
